// File: rtl/scaler_engine_if.sv
// Bus bundle for scaler_engine: job handshake, source ROM read port and frame RAM write port.
// The engine takes the slave side; the controller/memories take the master side.
interface scaler_engine_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SRC_AW = 15,
  parameter int unsigned DST_AW = 19
);
  logic              start;
  logic [1:0]        mode;
  logic              factor;
  logic              busy;
  logic              done;
  logic [SRC_AW-1:0] src_addr;
  logic [PIX_W-1:0]  src_data;
  logic [DST_AW-1:0] dst_addr;
  logic [PIX_W-1:0]  dst_data;
  logic              dst_wren;
  logic [9:0]        dst_w;
  logic [9:0]        dst_h;

  modport master (
    output start, mode, factor, src_data,
    input  busy, done, src_addr, dst_addr, dst_data, dst_wren, dst_w, dst_h
  );

  modport slave (
    input  start, mode, factor, src_data,
    output busy, done, src_addr, dst_addr, dst_data, dst_wren, dst_w, dst_h
  );
endinterface

// File: rtl/scaler_engine.sv
// Image scaler: reads a SRC_W x SRC_H image from a synchronous ROM and writes a x2/x4
// replicated, decimated, block-averaged or copied image in raster order to frame RAM.
module scaler_engine #(
  parameter int unsigned SRC_W  = 160,
  parameter int unsigned SRC_H  = 120,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SRC_AW = 15,
  parameter int unsigned DST_AW = 19
) (
  input logic            clk,
  input logic            rst,
  scaler_engine_if.slave bus
);

  localparam logic [1:0] ModeRep = 2'b00;
  localparam logic [1:0] ModeDec = 2'b01;
  localparam logic [1:0] ModeAvg = 2'b10;

  typedef enum logic [2:0] {StIdle, StRead, StSettle, StWrite, StFin} state_e;

  // Source address of read j (0..K-1) for destination pixel (x, y).
  function automatic logic [SRC_AW-1:0] src_addr_f(input logic [9:0] x, input logic [9:0] y,
                                                   input logic [3:0] j, input logic [1:0] mode,
                                                   input logic f4);
    logic [1:0]  s;
    logic [31:0] col;
    logic [31:0] row;
    s   = f4 ? 2'd2 : 2'd1;
    col = 32'(x);
    row = 32'(y);
    case (mode)
      ModeRep: begin
        col = col >> s;
        row = row >> s;
      end
      ModeDec: begin
        col = col << s;
        row = row << s;
      end
      ModeAvg: begin
        // Row-major walk of the F x F block: low bits of j pick the column.
        col = (col << s) + 32'(f4 ? j[1:0] : {1'b0, j[0]});
        row = (row << s) + 32'(f4 ? j[3:2] : {1'b0, j[1]});
      end
      default: ;
    endcase
    return SRC_AW'(row * SRC_W + col);
  endfunction

  function automatic logic [9:0] dim_f(input int unsigned src, input logic [1:0] mode,
                                       input logic f4);
    logic [1:0] s;
    s = f4 ? 2'd2 : 2'd1;
    case (mode)
      ModeRep:          return 10'(src << s);
      ModeDec, ModeAvg: return 10'(src >> s);
      default:          return 10'(src);
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              f4_q, f4_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [3:0]        rd_q, rd_d;
  logic [DST_AW-1:0] pix_q, pix_d;
  logic [PIX_W+3:0]  acc_q, acc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wren_q, wren_d;
  logic [SRC_AW-1:0] src_addr_q, src_addr_d;
  logic [DST_AW-1:0] dst_addr_q, dst_addr_d;
  logic [PIX_W-1:0]  dst_data_q, dst_data_d;
  logic [9:0]        dst_w_q, dst_w_d;
  logic [9:0]        dst_h_q, dst_h_d;

  logic [3:0]       k_last;
  logic [2:0]       shift;
  logic [PIX_W+3:0] sum;
  logic             last_x;
  logic             last_y;
  logic [9:0]       nx;
  logic [9:0]       ny;

  assign k_last = (mode_q == ModeAvg) ? (f4_q ? 4'd15 : 4'd3) : 4'd0;
  assign shift  = (mode_q == ModeAvg) ? (f4_q ? 3'd4 : 3'd2) : 3'd0;
  // ROM data seen now belongs to the address issued one cycle earlier.
  assign sum    = acc_q + (PIX_W+4)'(bus.src_data);
  assign last_x = (x_q == dst_w_q - 10'd1);
  assign last_y = (y_q == dst_h_q - 10'd1);
  assign nx     = last_x ? 10'd0 : x_q + 10'd1;
  assign ny     = last_x ? y_q + 10'd1 : y_q;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    f4_d       = f4_q;
    x_d        = x_q;
    y_d        = y_q;
    rd_d       = rd_q;
    pix_d      = pix_q;
    acc_d      = acc_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    dst_w_d    = dst_w_q;
    dst_h_d    = dst_h_q;
    wren_d     = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d     = bus.mode;
          f4_d       = bus.factor;
          dst_w_d    = dim_f(SRC_W, bus.mode, bus.factor);
          dst_h_d    = dim_f(SRC_H, bus.mode, bus.factor);
          x_d        = '0;
          y_d        = '0;
          rd_d       = '0;
          pix_d      = '0;
          acc_d      = '0;
          src_addr_d = src_addr_f(10'd0, 10'd0, 4'd0, bus.mode, bus.factor);
          state_d    = StRead;
        end
      end
      StRead: begin
        // First read cycle of a pixel has no sample yet; it clears the accumulator instead.
        acc_d = (rd_q == 4'd0) ? '0 : sum;
        if (rd_q == k_last) begin
          state_d = StSettle;
        end else begin
          rd_d       = rd_q + 4'd1;
          src_addr_d = src_addr_f(x_q, y_q, rd_q + 4'd1, mode_q, f4_q);
        end
      end
      StSettle: begin
        dst_data_d = PIX_W'(sum >> shift);
        dst_addr_d = pix_q;
        wren_d     = 1'b1;
        state_d    = StWrite;
      end
      StWrite: begin
        pix_d = pix_q + DST_AW'(1);
        rd_d  = '0;
        x_d   = nx;
        y_d   = ny;
        if (last_x && last_y) begin
          done_d  = 1'b1;
          state_d = StFin;
        end else begin
          src_addr_d = src_addr_f(nx, ny, 4'd0, mode_q, f4_q);
          state_d    = StRead;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      f4_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      rd_q       <= '0;
      pix_q      <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wren_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      f4_q       <= f4_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rd_q       <= rd_d;
      pix_q      <= pix_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wren_q     <= wren_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_w_q    <= dst_w_d;
      dst_h_q    <= dst_h_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dst_wren = wren_q;
  assign bus.src_addr = src_addr_q;
  assign bus.dst_addr = dst_addr_q;
  assign bus.dst_data = dst_data_q;
  assign bus.dst_w    = dst_w_q;
  assign bus.dst_h    = dst_h_q;

endmodule
